// File: rtl/frame_stats_if.sv
// frame_stats_if: sample input and result-record output of frame_stats, with master (producer/consumer side) and slave (frame_stats side) views.
interface frame_stats_if #(
  parameter int WIDTH = 16,
  parameter int SUM_WIDTH = 24,
  parameter int CNT_W = 5
);
  logic in_valid;
  logic in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic signed [SUM_WIDTH-1:0] out_sum;
  logic signed [WIDTH-1:0] out_min;
  logic signed [WIDTH-1:0] out_max;
  logic [CNT_W-1:0] out_count;
`ifdef FRAME_STATS_SAT_EN
  logic sum_sat;
  modport master (output in_valid, in_data, flush, out_ready,
                  input in_ready, out_valid, out_sum, out_min, out_max, out_count, sum_sat);
  modport slave (input in_valid, in_data, flush, out_ready,
                 output in_ready, out_valid, out_sum, out_min, out_max, out_count, sum_sat);
`else
  modport master (output in_valid, in_data, flush, out_ready,
                  input in_ready, out_valid, out_sum, out_min, out_max, out_count);
  modport slave (input in_valid, in_data, flush, out_ready,
                 output in_ready, out_valid, out_sum, out_min, out_max, out_count);
`endif
endinterface

// File: rtl/frame_stats.sv
// frame_stats: per-frame sum/min/max/count of a signed sample stream, one record per frame on valid/ready.
// Define FRAME_STATS_SAT_EN for a saturating sum plus the sum_sat record flag; default wraps.
module frame_stats #(
  parameter int WIDTH = 16,
  parameter int SUM_WIDTH = 24,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W = $clog2(FRAME_LEN+1)
) (
  input logic clk,
  input logic rst,
  frame_stats_if.slave bus
);
  typedef enum logic {ACC, HOLD} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic signed [SUM_WIDTH-1:0] sum, sum_n, dx;
  logic signed [WIDTH-1:0] mn, mx, mn_n, mx_n;
  logic acc, close;
  assign acc = state == ACC && bus.in_valid;
  assign dx = SUM_WIDTH'(bus.in_data);
`ifdef FRAME_STATS_SAT_EN
  logic signed [SUM_WIDTH-1:0] raw;
  logic clamp, sat_flag;
  assign raw = sum + dx;
  assign clamp = acc && sum[SUM_WIDTH-1] == dx[SUM_WIDTH-1] && raw[SUM_WIDTH-1] != sum[SUM_WIDTH-1];
  assign sum_n = clamp ? {sum[SUM_WIDTH-1], {(SUM_WIDTH-1){~sum[SUM_WIDTH-1]}}} : raw;
  always_ff @(posedge clk)
    if (rst) begin
      sat_flag <= 1'b0;
      bus.sum_sat <= 1'b0;
    end else if (close) begin
      sat_flag <= 1'b0;
      bus.sum_sat <= sat_flag | clamp;
    end else if (clamp) begin
      sat_flag <= 1'b1;
    end
`else
  assign sum_n = sum + dx;
`endif
  always_comb begin
    mn_n = (cnt == '0 || bus.in_data < mn) ? bus.in_data : mn;
    mx_n = (cnt == '0 || bus.in_data > mx) ? bus.in_data : mx;
    cnt_n = cnt + CNT_W'(1);
    close = state == ACC && ((acc && cnt == CNT_W'(FRAME_LEN-1)) || (bus.flush && (cnt != '0 || acc)));
  end
  always_ff @(posedge clk) state <= rst ? ACC : state_n;
  always_comb begin
    state_n = close ? HOLD : (state == HOLD && bus.out_ready) ? ACC : state;
    bus.in_ready = state == ACC;
    bus.out_valid = state == HOLD;
  end
  // The record includes the sample accepted on the closing edge.
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      sum <= '0;
      mn <= '0;
      mx <= '0;
      bus.out_sum <= '0;
      bus.out_min <= '0;
      bus.out_max <= '0;
      bus.out_count <= '0;
    end else if (close) begin
      bus.out_sum <= acc ? sum_n : sum;
      bus.out_min <= acc ? mn_n : mn;
      bus.out_max <= acc ? mx_n : mx;
      bus.out_count <= acc ? cnt_n : cnt;
      cnt <= '0;
      sum <= '0;
      mn <= '0;
      mx <= '0;
    end else if (acc) begin
      cnt <= cnt_n;
      sum <= sum_n;
      mn <= mn_n;
      mx <= mx_n;
    end
endmodule

// File: doc/frame_stats.md
Name: frame_stats

Overview:
- Downstream consumer of the signed WIDTH-bit polynomial-evaluator output stream.
- Accumulates running sum, minimum and maximum over frames of FRAME_LEN samples, then presents one result record on a valid/ready output.
- The upstream wrapper supplies in_valid, aligned to the polynomial stage's fixed latency.
- Applies back-pressure with in_ready while a result is pending.

Parameters:
- WIDTH, 16, sample width; in_data is signed two's complement.
- SUM_WIDTH, 24, accumulator and out_sum width; must be >= WIDTH.
- FRAME_LEN, 16, samples per frame; must be >= 1.
- CNT_W, $clog2(FRAME_LEN+1), width of the sample counter and out_count.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts a sample when in_valid && in_ready.
- in_data  in  WIDTH  signed sample.
- flush  in  1  one-cycle request to close the current partial frame.
- out_valid  out  1  result record valid.
- out_ready  in  1  downstream accepts the record when out_valid && out_ready.
- out_sum  out  SUM_WIDTH  signed sum of the frame's samples.
- out_min  out  WIDTH  signed minimum of the frame.
- out_max  out  WIDTH  signed maximum of the frame.
- out_count  out  CNT_W  number of samples in the record (1..FRAME_LEN).

Behaviour:
- Reset:
  - State ACC; counter = 0; accumulators cleared.
  - out_valid = 0; out_sum/out_min/out_max/out_count = 0.
  - in_ready = 1 from the first cycle after reset.
- States:
  - ACC: collecting samples; in_ready = 1; out_valid = 0.
  - HOLD: record pending; in_ready = 0; out_valid = 1.
- in_ready is a pure function of state. It is not combinationally dependent on out_ready.
- Accept in ACC (in_valid high):
  - Sample is sign-extended to SUM_WIDTH and added to sum; the addition wraps modulo 2^SUM_WIDTH.
  - On the first sample of a frame (counter == 0), min and max load in_data directly.
  - Otherwise min = smaller of (min, in_data) and max = larger of (max, in_data), by signed compare.
  - counter increments.
- Frame close, ACC -> HOLD, on the same edge as one of:
  - a sample is accepted while counter == FRAME_LEN-1;
  - flush is high with counter > 0;
  - flush is high, counter == 0 and a sample is accepted in that cycle.
- Frame close actions:
  - Output registers load the updated sum/min/max/count, including the sample accepted in that cycle.
  - Accumulators and counter clear.
  - out_valid rises on the following cycle.
- flush is ignored when:
  - counter == 0 and no sample is accepted;
  - the block is in HOLD. No flush is remembered.
- HOLD -> ACC when out_ready is high.
  - out_valid falls on the next cycle.
  - Output data registers keep their last values; they are not cleared.
- Minimum frame gap:
  - A full-rate input loses one accept slot per frame: the HOLD cycle.
  - This is for out_ready held high.
- While out_valid is high and out_ready is low, all out_* are stable.
- Reset mid-frame or in HOLD: the partial frame or pending record is discarded with no output. All reset values apply on the next cycle.
- FRAME_LEN = 1: every accepted sample closes a frame with out_count = 1 and out_min = out_max = sample.

Optional Feature:
- Macro: FRAME_STATS_SAT_EN.
- Defined: the sum add saturates.
  - Result is clamped to +2^(SUM_WIDTH-1)-1 or -2^(SUM_WIDTH-1).
  - Output port sum_sat (1 bit, reset 0) is added. It is high with a record if any clamp occurred in that frame; sat_flag is cleared at frame close.
- Undefined: the sum add wraps modulo 2^SUM_WIDTH. No sum_sat port exists.

Test Plan:
- Full frame, FRAME_LEN=4:
  - Stimulus: samples 3, -5, 7, 0 back-to-back; out_ready=1.
  - Required: one record with sum=5, min=-5, max=7, count=4.
  - Required: in_ready low for exactly one cycle; out_valid high for exactly one cycle.
- Back-pressure:
  - Stimulus: complete a frame; hold out_ready=0 for 5 cycles.
  - Required: out_* stable and in_ready=0 throughout; record consumed on the cycle out_ready=1; ACC the next cycle.
- Flush:
  - Stimulus: samples 10, 20, then flush alone.
  - Required: record sum=30, min=10, max=20, count=2.
  - Stimulus: flush with counter=0 and no sample.
  - Required: no record.
  - Stimulus: flush together with a sample at counter=0.
  - Required: count=1.
- Wrap vs saturate, SUM_WIDTH=16, WIDTH=16, FRAME_LEN=2:
  - Stimulus: 32767, 1.
  - Required without macro: sum=-32768.
  - Required with FRAME_STATS_SAT_EN: sum=32767, sum_sat=1.
- Reset mid-frame:
  - Stimulus: 2 of 4 samples accepted, then rst for 1 cycle, then 4 samples of 1.
  - Required: the only record is sum=4, count=4; outputs are 0 and out_valid=0 during and right after reset.
- Min/max extremes:
  - Stimulus: samples -32768, 32767, -1, 0.
  - Required: min=-32768, max=32767, sum=-2.
